sigma_accum_seq: RTL and testbench

//  Sequences the shared 4-input signed-magnitude adder tree (sigma4) to form one neuron's

---
 rtl/sigma_seq_pkg.sv | 7 +
 rtl/adder.sv | 20 ++
 rtl/sigma4.sv | 17 +
 rtl/sigma_accum_seq.sv | 81 ++++++++
 tb/tb_sigma_accum_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/sigma_seq_pkg.sv
// sigma_seq_pkg: shared data width and sequencer state encoding
//   N            data width of signed-magnitude values (MSB sign, 8 fraction bits)
//   seq_state_t  IDLE, ACCUM, DRAIN, DONE
package sigma_seq_pkg;
    localparam int N = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/adder.sv
// adder: N-bit signed-magnitude adder, magnitude wraps, zero result is always +0
//   a, b  in   N  signed-magnitude operands
//   s     out  N  signed-magnitude sum
module adder
    import sigma_seq_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s
);
    logic [N-2:0] ma, mb, mag;
    logic same, a_ge, sg;
    assign ma   = a[N-2:0];
    assign mb   = b[N-2:0];
    assign same = a[N-1] == b[N-1];
    assign a_ge = ma >= mb;
    assign mag  = same ? ma + mb : (a_ge ? ma - mb : mb - ma);
    assign sg   = same ? a[N-1] : (a_ge ? a[N-1] : b[N-1]);
    assign s    = {sg && (mag != '0), mag};
endmodule

// File: rtl/sigma4.sv
// sigma4: balanced tree of three signed-magnitude adders summing four values
//   a0..a3  in   N  signed-magnitude inputs
//   s       out  N  (a0+a1)+(a2+a3)
module sigma4
    import sigma_seq_pkg::*;
(
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    output logic [N-1:0] s
);
    logic [N-1:0] s01, s23;
    adder u_a01 (.a(a0),  .b(a1),  .s(s01));
    adder u_a23 (.a(a2),  .b(a3),  .s(s23));
    adder u_top (.a(s01), .b(s23), .s(s));
endmodule

// File: rtl/sigma_accum_seq.sv
// sigma_accum_seq: accumulates n_groups sigma4 group sums into one neuron's weighted sum
//   clk, rst             clock, async active-high reset
//   start, n_groups      begin a sum of n_groups groups (IDLE only)
//   in_valid, in_ready   group stream handshake; a0..a3 carry the group
//   out_valid, out_ready result handshake; sum holds the result while out_valid
//   busy                 high whenever not IDLE
module sigma_accum_seq
    import sigma_seq_pkg::*;
#(
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [GW-1:0] n_groups,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a0,
    input  logic [N-1:0]  a1,
    input  logic [N-1:0]  a2,
    input  logic [N-1:0]  a3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          busy
);
    seq_state_t    state, state_nx;
    logic [GW-1:0] cnt;
    logic [N-1:0]  grp, psum_q, acc, acc_nx;
    logic          psum_v, beat;

    sigma4 u_sigma4 (.a0(a0), .a1(a1), .a2(a2), .a3(a3), .s(grp));
    adder  u_adder  (.a(acc), .b(psum_q), .s(acc_nx));

    assign beat = in_valid && in_ready;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE:  if (start) state_nx = (n_groups != '0) ? ACCUM : DONE;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == GW'(1)) state_nx = DRAIN;
            end
            DRAIN: state_nx = DONE;
            DONE:  begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        sum = out_valid ? acc : '0;
    end

    // The partial sum registered on one beat folds into acc on the next edge,
    // overlapping with the following beat; DRAIN folds the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            psum_q <= '0;
            psum_v <= 1'b0;
            acc    <= '0;
        end else begin
            state  <= state_nx;
            psum_v <= beat;
            if (beat) begin
                psum_q <= grp;
                cnt    <= cnt - 1'b1;
            end
            if (psum_v) acc <= acc_nx;
            if (state == IDLE && start) begin
                acc <= '0;
                cnt <= n_groups;
            end
        end
    end
endmodule

// File: tb/tb_sigma_accum_seq.sv
// tb_sigma_accum_seq: directed table-driven bench for sigma_accum_seq plus multi-cycle corner sequences
module tb_sigma_accum_seq;
    localparam logic [15:0] P1 = 16'h0100, M1 = 16'h8100, PH = 16'h0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  n_groups;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a0, a1, a2, a3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        busy;

    int total = 0;
    int passed = 0;
    int beats = 0;

    sigma_accum_seq #(.GW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .n_groups(n_groups),
        .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready) beats <= beats + 1;

    typedef struct {
        string                   name;
        int                      n;
        int                      bub;
        logic [2:0][3:0][15:0]   g;
        logic [15:0]             exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [3:0][15:0] g);
        a0 = g[0]; a1 = g[1]; a2 = g[2]; a3 = g[3];
    endtask

    task automatic run_sum(input string name, input int n, input int bub,
                           input logic [2:0][3:0][15:0] g, input logic [15:0] exp);
        int b0;
        b0 = beats;
        start = 1'b1;
        n_groups = 4'(n);
        tick;
        start = 1'b0;
        if (n == 0) chk({name, " in_ready"}, 16'(in_ready), 16'd0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < bub; k++) begin
                in_valid = 1'b0;
                tick;
            end
            drive(g[i]);
            in_valid = 1'b1;
            chk({name, " ready"}, 16'(in_ready), 16'd1);
            tick;
        end
        if (n != 0) begin
            chk({name, " drain in_ready"}, 16'(in_ready), 16'd0);
            chk({name, " drain out_valid"}, 16'(out_valid), 16'd0);
            tick;
        end
        in_valid = 1'b0;
        chk({name, " out_valid"}, 16'(out_valid), 16'd1);
        chk({name, " sum"}, sum, exp);
        chk({name, " beats"}, 16'(beats - b0), 16'(n));
        tick;
        chk({name, " out_valid after"}, 16'(out_valid), 16'd0);
        chk({name, " busy after"}, 16'(busy), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"one_group", 1, 0, '{'0, '0, '{P1, P1, P1, P1}}, 16'h0400};
        vecs[1] = '{"three_bubbles", 3, 2, '{'{PH, PH, PH, PH}, '{16'h0000, 16'h0000, M1, M1}, '{P1, P1, P1, P1}}, 16'h0400};
        vecs[2] = '{"zero_groups", 0, 0, '{'0, '0, '0}, 16'h0000};
        vecs[3] = '{"cancel_then_pos", 2, 1, '{'0, '{16'h0000, 16'h0000, 16'h0000, 16'h0300}, '{16'h8080, PH, M1, P1}}, 16'h0300};
        vecs[4] = '{"mixed_sign", 2, 0, '{'0, '{16'h0000, 16'h0000, P1, P1}, '{M1, M1, M1, M1}}, 16'h8200};
        vecs[5] = '{"neg_zero_in", 1, 0, '{'0, '0, '{PH, 16'h8000, 16'h8000, 16'h8000}}, 16'h0080};

        rst = 1'b1; start = 1'b0; n_groups = '0; in_valid = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0; out_ready = 1'b1;
        tick;
        chk("reset in_ready", 16'(in_ready), 16'd0);
        chk("reset out_valid", 16'(out_valid), 16'd0);
        chk("reset sum", sum, 16'h0000);
        chk("reset busy", 16'(busy), 16'd0);
        rst = 1'b0;
        tick;

        foreach (vecs[i]) run_sum(vecs[i].name, vecs[i].n, vecs[i].bub, vecs[i].g, vecs[i].exp);

        // Held result with stalled consumer; start pulses in DONE are ignored.
        out_ready = 1'b0;
        start = 1'b1; n_groups = 4'd2; tick; start = 1'b0;
        drive('{M1, M1, M1, M1}); in_valid = 1'b1; tick; tick; in_valid = 1'b0;
        tick;
        for (int c = 0; c < 5; c++) begin
            start = (c % 2) == 0;
            n_groups = 4'd1;
            chk("hold out_valid", 16'(out_valid), 16'd1);
            chk("hold sum", sum, 16'h8800);
            chk("hold in_ready", 16'(in_ready), 16'd0);
            tick;
        end
        // start during the handoff cycle is also ignored
        start = 1'b1; out_ready = 1'b1;
        chk("hold last sum", sum, 16'h8800);
        tick;
        start = 1'b0;
        chk("handoff out_valid", 16'(out_valid), 16'd0);
        chk("handoff busy", 16'(busy), 16'd0);
        tick;
        chk("handoff stays idle", 16'(busy), 16'd0);

        // Reset mid-ACCUM after 1 of 3 beats
        start = 1'b1; n_groups = 4'd3; tick; start = 1'b0;
        drive('{P1, P1, P1, P1}); in_valid = 1'b1; tick; in_valid = 1'b0; tick;
        chk("mid busy before rst", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("rst in_ready", 16'(in_ready), 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        chk("rst out_valid", 16'(out_valid), 16'd0);
        chk("rst sum", sum, 16'h0000);
        tick;
        rst = 1'b0;
        tick;
        run_sum("after_reset", 1, 0, '{'0, '0, '{16'h0000, 16'h0000, 16'h0000, P1}}, 16'h0100);

        // Back-to-back independent sums
        run_sum("b2b_first", 1, 0, '{'0, '0, '{P1, P1, P1, P1}}, 16'h0400);
        run_sum("b2b_second", 1, 0, '{'0, '0, '{16'h0000, 16'h0000, 16'h0000, 16'h8080}}, 16'h8080);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
